case_5_mul_arbiter: RTL and testbench

CASE_5_MUL_ARBITER -- requirements
Module: case_5_mul_arbiter

---
 rtl/case_5_mul_arbiter.sv | 116 +++++++++++
 tb/tb_case_5_mul_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/case_5_mul_arbiter.sv
// case_5_mul_arbiter: round-robin share of one signed multiplier, result registered 1 cycle after grant.
// No grants while a result is held (res_vld && !res_rdy); res_cnt is live only with CASE_5_MUL_ARB_CNT_EN.
module case_5_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DIN_WIDTH  = 4,
  parameter int DOUT_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic [NUM_REQ-1:0]             req_vld,
  output logic [NUM_REQ-1:0]             req_rdy,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_b,
  output logic                           res_vld,
  input  logic                           res_rdy,
  output logic [DOUT_WIDTH-1:0]          res_data,
  output logic [ID_WIDTH-1:0]            res_id,
  output logic [15:0]                    res_cnt
);

  typedef struct packed {
    logic [DOUT_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } res_t;

  logic [ID_WIDTH-1:0]          ptr;
  logic [ID_WIDTH-1:0]          cand;
  logic [ID_WIDTH-1:0]          win_idx;
  logic                         win_any;
  logic                         reg_free;
  logic                         grant;
  logic signed [DIN_WIDTH-1:0]  op_a;
  logic signed [DIN_WIDTH-1:0]  op_b;
  logic signed [DOUT_WIDTH-1:0] product;
  res_t                         res_q;
  logic                         res_vld_q;

  assign reg_free = !res_vld_q || res_rdy;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (!win_any && req_vld[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Reset gates the grant so req_rdy stays low while ap_rst_n is asserted.
  assign grant = ap_rst_n && reg_free && win_any;

  always_comb begin
    req_rdy = '0;
    if (grant) begin
      req_rdy[win_idx] = 1'b1;
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_WIDTH'(i)) begin
        op_a = req_a[i*DIN_WIDTH +: DIN_WIDTH];
        op_b = req_b[i*DIN_WIDTH +: DIN_WIDTH];
      end
    end
  end

  // The single shared multiplier; operands are sign-extended to the full product width.
  assign product = DOUT_WIDTH'(op_a) * DOUT_WIDTH'(op_b);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      res_vld_q <= 1'b0;
      res_q     <= '0;
      ptr       <= '0;
    end else begin
      if (grant) begin
        res_vld_q  <= 1'b1;
        res_q.data <= product;
        res_q.id   <= win_idx;
        ptr        <= (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (res_rdy) begin
        res_vld_q <= 1'b0;
      end
    end
  end

  assign res_vld  = res_vld_q;
  assign res_data = res_q.data;
  assign res_id   = res_q.id;

`ifdef CASE_5_MUL_ARB_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q <= '0;
    end else if (res_vld_q && res_rdy && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign res_cnt = cnt_q;
`else
  assign res_cnt = '0;
`endif

endmodule

// File: tb/tb_case_5_mul_arbiter.sv
// Self-checking bench for case_5_mul_arbiter: directed vector table, reset/round-robin sequences,
// and randomized traffic against a transaction-level model of arbitration and products.
module tb_case_5_mul_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic         ap_clk;
  logic         ap_rst_n;
  logic [N-1:0] req_vld;
  logic [N-1:0] req_rdy;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic         res_vld;
  logic         res_rdy;
  logic [7:0]   res_data;
  logic [1:0]   res_id;
  logic [15:0]  res_cnt;

  case_5_mul_arbiter dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_a    (req_a),
    .req_b    (req_b),
    .res_vld  (res_vld),
    .res_rdy  (res_rdy),
    .res_data (res_data),
    .res_id   (res_id),
    .res_cnt  (res_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_vld;
  logic [7:0] m_data;
  int         m_id;
  int         m_ptr;
  int         m_acc;
  int         nxt_w;

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] a;
    logic [15:0] b;
    logic        rdy;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [7:0]  exp_data;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (!ap_rst_n) return -1;
    if (m_vld && !res_rdy) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int exp_cnt();
`ifdef CASE_5_MUL_ARB_CNT_EN
    return (m_acc > 65535) ? 65535 : m_acc;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_id   = 0;
    m_ptr  = 0;
    m_acc  = 0;
  endtask

  // Called at the negative edge: compare outputs with the model and predict this cycle's grant.
  task automatic pre();
    logic [3:0] er;
    nxt_w = winner();
    er = (nxt_w >= 0) ? 4'(1 << nxt_w) : 4'b0000;
    chk("req_rdy", 32'(req_rdy), 32'(er));
    chk("res_vld", 32'(res_vld), 32'(m_vld));
    if (m_vld) begin
      chk("res_data", 32'(res_data), 32'(m_data));
      chk("res_id", 32'(res_id), 32'(m_id));
    end
    chk("res_cnt", 32'(res_cnt), 32'(exp_cnt()));
  endtask

  task automatic post();
    int p;
    @(posedge ap_clk);
    if (ap_rst_n) begin
      if (m_vld && res_rdy) m_acc++;
      if (nxt_w >= 0) begin
        p = int'($signed(req_a[nxt_w*W +: W])) * int'($signed(req_b[nxt_w*W +: W]));
        m_vld  = 1'b1;
        m_data = 8'(p);
        m_id   = nxt_w;
        m_ptr  = (nxt_w + 1) % N;
      end else if (res_rdy) begin
        m_vld = 1'b0;
      end
    end
    #1;
  endtask

  task automatic cyc();
    @(negedge ap_clk);
    pre();
    post();
  endtask

  function automatic vec_t mk(input logic [3:0] vld, input logic [15:0] a, input logic [15:0] b,
                              input logic rdy, input logic [3:0] er, input logic ev,
                              input logic [7:0] ed, input logic [1:0] ei);
    vec_t v;
    v.vld = vld; v.a = a; v.b = b; v.rdy = rdy;
    v.exp_rdy = er; v.exp_vld = ev; v.exp_data = ed; v.exp_id = ei;
    return v;
  endfunction

  initial begin
    int x;
    // Rows run back to back from reset; ptr evolves 0,1,2,3,1,0,0,1,1,1,1,2.
    tbl[0]  = mk(4'b0001, 16'h0003, 16'h0005, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0);
    tbl[1]  = mk(4'b0010, 16'h0080, 16'h0080, 1'b1, 4'b0010, 1'b1, 8'h40, 2'd1);
    tbl[2]  = mk(4'b0100, 16'h0700, 16'h0800, 1'b1, 4'b0100, 1'b1, 8'hC8, 2'd2);
    tbl[3]  = mk(4'b0001, 16'h0008, 16'h0007, 1'b1, 4'b0001, 1'b1, 8'hC8, 2'd0);
    tbl[4]  = mk(4'b1001, 16'hF001, 16'hF001, 1'b1, 4'b1000, 1'b1, 8'h01, 2'd3);
    tbl[5]  = mk(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    tbl[6]  = mk(4'b1111, 16'h0052, 16'h005D, 1'b0, 4'b0001, 1'b1, 8'hFA, 2'd0);
    tbl[7]  = mk(4'b1111, 16'h0052, 16'h005D, 1'b0, 4'b0000, 1'b1, 8'hFA, 2'd0);
    tbl[8]  = mk(4'b1111, 16'h0052, 16'h005D, 1'b0, 4'b0000, 1'b1, 8'hFA, 2'd0);
    tbl[9]  = mk(4'b1111, 16'h0052, 16'h005D, 1'b0, 4'b0000, 1'b1, 8'hFA, 2'd0);
    tbl[10] = mk(4'b1111, 16'h0052, 16'h005D, 1'b1, 4'b0010, 1'b1, 8'h19, 2'd1);
    tbl[11] = mk(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);

    ap_rst_n = 1'b0;
    req_vld  = '0;
    req_a    = '0;
    req_b    = '0;
    res_rdy  = 1'b0;
    model_reset();
    #1;
    chk("rst_vld", 32'(res_vld), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    chk("rst_cnt", 32'(res_cnt), 32'd0);
    req_vld = 4'b1111;
    #1;
    chk("rst_rdy", 32'(req_rdy), 32'd0);
    req_vld = '0;
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    foreach (tbl[i]) begin
      req_vld = tbl[i].vld;
      req_a   = tbl[i].a;
      req_b   = tbl[i].b;
      res_rdy = tbl[i].rdy;
      @(negedge ap_clk);
      pre();
      chk($sformatf("tbl%0d_rdy", i), 32'(req_rdy), 32'(tbl[i].exp_rdy));
      post();
      chk($sformatf("tbl%0d_vld", i), 32'(res_vld), 32'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) begin
        chk($sformatf("tbl%0d_data", i), 32'(res_data), 32'(tbl[i].exp_data));
        chk($sformatf("tbl%0d_id", i), 32'(res_id), 32'(tbl[i].exp_id));
      end
    end

    // Reset while a result is pending, then first grant must start from ptr 0.
    req_vld = 4'b0100;
    req_a   = 16'h0300;
    req_b   = 16'h0300;
    res_rdy = 1'b0;
    cyc();
    chk("pend_vld", 32'(res_vld), 32'd1);
    ap_rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_vld", 32'(res_vld), 32'd0);
    chk("mid_rst_data", 32'(res_data), 32'd0);
    chk("mid_rst_id", 32'(res_id), 32'd0);
    chk("mid_rst_rdy", 32'(req_rdy), 32'd0);
    cyc();
    cyc();
    ap_rst_n = 1'b1;
    req_vld  = 4'b1000;
    req_a    = 16'h2000;
    req_b    = 16'hC000;
    res_rdy  = 1'b1;
    @(negedge ap_clk);
    pre();
    chk("post_rst_rdy", 32'(req_rdy), 32'b1000);
    post();
    chk("post_rst_id", 32'(res_id), 32'd3);
    chk("post_rst_data", 32'(res_data), 32'hF8);

    // All requesters held valid with a free consumer: ids rotate 0,1,2,3,0 without bubbles.
    req_vld = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      cyc();
      chk($sformatf("rr%0d_vld", c), 32'(res_vld), 32'd1);
      chk($sformatf("rr%0d_id", c), 32'(res_id), 32'(c % N));
    end

    for (int c = 0; c < 600; c++) begin
      req_vld = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        x = $urandom_range(0, 15) - 8;
        req_a[i*W +: W] = 4'(x);
        x = $urandom_range(0, 15) - 8;
        req_b[i*W +: W] = 4'(x);
      end
      res_rdy = ($urandom_range(0, 9) < 7);
      cyc();
    end

`ifdef CASE_5_MUL_ARB_CNT_EN
    req_vld = 4'b1111;
    res_rdy = 1'b1;
    repeat (70000) @(posedge ap_clk);
    #1;
    chk("cnt_sat", 32'(res_cnt), 32'hFFFF);
    repeat (3) @(posedge ap_clk);
    #1;
    chk("cnt_hold", 32'(res_cnt), 32'hFFFF);
`else
    req_vld = 4'b1111;
    res_rdy = 1'b1;
    repeat (20) @(posedge ap_clk);
    #1;
    chk("cnt_off", 32'(res_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
